ula_pipe: RTL and testbench

Parametrised, two-stage pipelined successor to the MIC-1 combinational ULA. It keeps the same 8-bit control word (SLL8, SRA1, F0, F1, ENA, ENB, INVA, INC) and adds:
- generic datapath width;
- a configurable left-shift amount;
- carry and overflow flags;
- valid/ready handshakes on input and output, so the datapath controller can stall it.

It sits between the B-bus/H-register operand sources and the C-bus writeback.

---
 rtl/ula_pkg.sv | 27 ++
 rtl/ula_core.sv | 55 +++++
 rtl/ula_pipe.sv | 132 +++++++++++++
 tb/tb_ula_pipe.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// ula_pkg: shared constants for the pipelined ULA (control-word bit positions, ALU function codes).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ula_pkg;

    // Bit positions inside the 8-bit MIC-1 control word
    localparam int SEL_SLL8 = 7;
    localparam int SEL_SRA1 = 6;
    localparam int SEL_F0   = 5;
    localparam int SEL_F1   = 4;
    localparam int SEL_ENA  = 3;
    localparam int SEL_ENB  = 2;
    localparam int SEL_INVA = 1;
    localparam int SEL_INC  = 0;

    // ALU function codes, formed as {F0, F1}
    localparam logic [1:0] F_AND  = 2'b00;
    localparam logic [1:0] F_OR   = 2'b01;
    localparam logic [1:0] F_NOTB = 2'b10;
    localparam logic [1:0] F_ADD  = 2'b11;

    // Extract the function code from a control word
    function automatic logic [1:0] f_code(input logic [7:0] sel);
        return {sel[SEL_F0], sel[SEL_F1]};
    endfunction

endpackage

// File: rtl/ula_core.sv
// ula_core: combinational MIC-1 ALU (operand gating, AND/OR/NOTB/ADD, N/Z/C/V flags).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the enclosing pipeline decides when results are captured.
module ula_core
    import ula_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [7:0]       select,
    output logic [WIDTH-1:0] result,
    output logic             N,
    output logic             Z,
    output logic             C,
    output logic             V
);

    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH:0]   w_sum;

    // Operand gating and the one-bit-wider adder shared by the ADD function
    always_comb begin
        w_a = select[SEL_ENA] ? A : '0;
        if (select[SEL_INVA]) begin
            w_a = ~w_a;
        end
        w_b   = select[SEL_ENB] ? B : '0;
        w_sum = {1'b0, w_a} + {1'b0, w_b} + {{WIDTH{1'b0}}, select[SEL_INC]};
    end

    // Function select; carry/overflow only meaningful for ADD, forced to 0 otherwise
    always_comb begin
        result = '0;
        C      = 1'b0;
        V      = 1'b0;
        case (f_code(select))
            F_AND:   result = w_a & w_b;
            F_OR:    result = w_a | w_b;
            F_NOTB:  result = ~w_b;
            F_ADD: begin
                result = w_sum[WIDTH-1:0];
                C      = w_sum[WIDTH];
                V      = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);
            end
            default: result = '0;
        endcase
    end

    // Jump flags look at the ALU result before the shifter
    assign N = result[WIDTH-1];
    assign Z = (result == '0);

endmodule

// File: rtl/ula_pipe.sv
// ula_pipe: two-stage pipelined MIC-1 ULA; stage 1 registers the ALU, stage 2 registers the shifter.
// Latency: 2 cycles from accept to result; throughput 1 op/clock with out_ready high.
// Backpressure: holds up to 2 ops when stalled; in_ready is combinational from out_ready and the valid bits.
module ula_pipe
    import ula_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SLL_AMT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [7:0]       select,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out,
    output logic             N,
    output logic             Z,
    output logic             C,
    output logic             V,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [WIDTH-1:0] w_res;
    logic             w_n;
    logic             w_z;
    logic             w_c;
    logic             w_v;
    logic             w_s1_load;
    logic             w_s2_load;
    logic [WIDTH-1:0] w_shifted;

    logic [WIDTH-1:0] r_s1_res;
    logic             r_s1_n;
    logic             r_s1_z;
    logic             r_s1_c;
    logic             r_s1_v;
    logic             r_s1_sll;
    logic             r_s1_sra;
    logic             r_s1_vld;

    logic [WIDTH-1:0] r_s2_out;
    logic             r_s2_n;
    logic             r_s2_z;
    logic             r_s2_c;
    logic             r_s2_v;
    logic             r_s2_vld;

    ula_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .A      (A),
        .B      (B),
        .select (select),
        .result (w_res),
        .N      (w_n),
        .Z      (w_z),
        .C      (w_c),
        .V      (w_v)
    );

    // A stage advances when it is empty or the stage downstream is advancing
    assign w_s2_load = !r_s2_vld || out_ready;
    assign w_s1_load = !r_s1_vld || w_s2_load;
    assign in_ready  = w_s1_load;

    // Shifter: left shift has priority over the arithmetic right shift
    always_comb begin
        w_shifted = r_s1_res;
        if (r_s1_sll) begin
            w_shifted = r_s1_res << SLL_AMT;
        end else if (r_s1_sra) begin
            w_shifted = {r_s1_res[WIDTH-1], r_s1_res[WIDTH-1:1]};
        end
    end

    // Stage 1: capture ALU result, flags and shift controls on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld <= 1'b0;
            r_s1_res <= '0;
            r_s1_n   <= 1'b0;
            r_s1_z   <= 1'b0;
            r_s1_c   <= 1'b0;
            r_s1_v   <= 1'b0;
            r_s1_sll <= 1'b0;
            r_s1_sra <= 1'b0;
        end else if (w_s1_load) begin
            r_s1_vld <= in_valid;
            if (in_valid) begin
                r_s1_res <= w_res;
                r_s1_n   <= w_n;
                r_s1_z   <= w_z;
                r_s1_c   <= w_c;
                r_s1_v   <= w_v;
                r_s1_sll <= select[SEL_SLL8];
                r_s1_sra <= select[SEL_SRA1];
            end
        end
    end

    // Stage 2: capture shifted result; holds while stalled so outputs stay stable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_vld <= 1'b0;
            r_s2_out <= '0;
            r_s2_n   <= 1'b0;
            r_s2_z   <= 1'b0;
            r_s2_c   <= 1'b0;
            r_s2_v   <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_s2_out <= w_shifted;
                r_s2_n   <= r_s1_n;
                r_s2_z   <= r_s1_z;
                r_s2_c   <= r_s1_c;
                r_s2_v   <= r_s1_v;
            end
        end
    end

    assign out       = r_s2_out;
    assign N         = r_s2_n;
    assign Z         = r_s2_z;
    assign C         = r_s2_c;
    assign V         = r_s2_v;
    assign out_valid = r_s2_vld;

endmodule

// File: tb/tb_ula_pipe.sv
// tb_ula_pipe: directed checks of ula_pipe (ALU functions, flags, shifter, latency, stall, reset flush).
// Latency: expects out_valid one negedge after the edge following accept (consumer takes it on edge k+2).
// Backpressure: exercises a full 2-deep stall and simultaneous drain/accept.
module tb_ula_pipe;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [W-1:0]  A;
    logic [W-1:0]  B;
    logic [7:0]    select;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  out;
    logic          N;
    logic          Z;
    logic          C;
    logic          V;
    logic          out_valid;
    logic          out_ready;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] ra [8];
    logic [31:0] rb [8];
    logic [7:0]  rs [8];
    logic [35:0] rexp [8];

    always #5 clk = ~clk;

    ula_pipe #(
        .WIDTH   (W),
        .SLL_AMT (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (A),
        .B         (B),
        .select    (select),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .N         (N),
        .Z         (Z),
        .C         (C),
        .V         (V),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [7:0] s, input logic v);
        A        = a;
        B        = b;
        select   = s;
        in_valid = v;
    endtask

    // Issue one op into an empty pipe and check 2-cycle latency, result and {N,Z,C,V}
    task automatic single(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [7:0] s, input logic [31:0] exp_out, input logic [3:0] exp_fl);
        @(negedge clk);
        drive(a, b, s, 1'b1);
        check({tag, " in_ready"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, " early_vld"}, out_valid, 0);
        @(negedge clk);
        check({tag, " out_valid"}, out_valid, 1);
        check({tag, " out"}, out, exp_out);
        check({tag, " flags"}, {N, Z, C, V}, exp_fl);
    endtask

    // Reference behaviour for arbitrary control words: {out, N, Z, C, V}
    function automatic logic [35:0] ref_op(input logic [31:0] ai, input logic [31:0] bi, input logic [7:0] s);
        logic [32:0] a;
        logic [32:0] b;
        logic [32:0] r;
        logic [31:0] res;
        logic [31:0] sh;
        logic        c;
        logic        v;
        a = s[3] ? {1'b0, ai} : 33'd0;
        if (s[1]) a[31:0] = ~a[31:0];
        b = s[2] ? {1'b0, bi} : 33'd0;
        c = 1'b0;
        v = 1'b0;
        case ({s[5], s[4]})
            2'b00:   r = a & b;
            2'b01:   r = a | b;
            2'b10:   r = {1'b0, ~b[31:0]};
            default: begin
                r = a + b + {32'd0, s[0]};
                c = r[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
        endcase
        res = r[31:0];
        if (s[7])      sh = res << 8;
        else if (s[6]) sh = {res[31], res[31:1]};
        else           sh = res;
        return {sh, res[31], (res == 32'd0), c, v};
    endfunction

    initial begin
        drive(32'd0, 32'd0, 8'd0, 1'b0);
        out_ready = 1'b1;

        // Asynchronous reset, before any clock edge has reached the DUT
        #2 rst_n = 1'b0;
        #1;
        check("rst out_valid", out_valid, 0);
        check("rst out", out, 0);
        check("rst flags", {N, Z, C, V}, 4'b0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post-rst in_ready", in_ready, 1);

        // Adder basics
        single("add 1+2",      32'd1,        32'd2, 8'b0011_1100, 32'd3,        4'b0000);
        single("add 1+2+inc",  32'd1,        32'd2, 8'b0011_1101, 32'd4,        4'b0000);
        single("add ovf",      32'h7FFF_FFFF, 32'd1, 8'b0011_1100, 32'h8000_0000, 4'b1001);
        single("add carry",    32'hFFFF_FFFF, 32'd1, 8'b0011_1100, 32'd0,        4'b0110);
        // ~A + B + 1 = B - A = 3 - 5
        single("sub",          32'd5,        32'd3, 8'b0011_1111, 32'hFFFF_FFFE, 4'b1000);
        single("notb",         32'd7,        32'd0, 8'b0010_0100, 32'hFFFF_FFFF, 4'b1000);
        single("and inc-ign",  32'd9,        32'd9, 8'b0000_0001, 32'd0,        4'b0100);

        // Shifter, flags taken before the shift
        single("sll8",         32'h12,        32'd0, 8'b1001_1000, 32'h1200,     4'b0000);
        single("sra1",         32'h8000_0000, 32'd0, 8'b0101_1000, 32'hC000_0000, 4'b1000);
        single("sll wins",     32'h12,        32'd0, 8'b1101_1000, 32'h1200,     4'b0000);

        // Back-to-back random ops: one result per clock, two cycles after the first accept
        for (int i = 0; i < 8; i++) begin
            ra[i]   = $urandom;
            rb[i]   = $urandom;
            rs[i]   = 8'($urandom_range(0, 255));
            rexp[i] = ref_op(ra[i], rb[i], rs[i]);
        end
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check($sformatf("b2b vld c%0d", c), out_valid, (c >= 2 && c < 10));
            if (c >= 2 && c < 10) begin
                check($sformatf("b2b res %0d", c - 2), {out, N, Z, C, V}, rexp[c-2]);
            end
            if (c < 8) drive(ra[c], rb[c], rs[c], 1'b1);
            else       in_valid = 1'b0;
        end

        // Backpressure: 5, 6, 7 issued with the consumer stalled
        @(negedge clk);
        out_ready = 1'b0;
        drive(32'd5, 32'd0, 8'b0001_1000, 1'b1);
        check("bp rdy1", in_ready, 1);
        @(negedge clk);
        drive(32'd6, 32'd0, 8'b0001_1000, 1'b1);
        check("bp rdy2", in_ready, 1);
        @(negedge clk);
        drive(32'd7, 32'd0, 8'b0001_1000, 1'b1);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            check($sformatf("bp full rdy%0d", k), in_ready, 0);
            check($sformatf("bp hold vld%0d", k), out_valid, 1);
            check($sformatf("bp hold out%0d", k), out, 32'd5);
        end
        out_ready = 1'b1;
        #1;
        check("bp rdy release", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp drain 6 vld", out_valid, 1);
        check("bp drain 6", out, 32'd6);
        @(negedge clk);
        check("bp drain 7 vld", out_valid, 1);
        check("bp drain 7", out, 32'd7);
        @(negedge clk);
        check("bp empty", out_valid, 0);

        // Reset with both stages holding work
        out_ready = 1'b0;
        drive(32'd11, 32'd0, 8'b0001_1000, 1'b1);
        @(negedge clk);
        drive(32'd12, 32'd0, 8'b0001_1000, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        check("pre-flush vld", out_valid, 1);
        check("pre-flush out", out, 32'd11);
        #2 rst_n = 1'b0;
        #1;
        check("flush vld", out_valid, 0);
        check("flush out", out, 0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("flush in_ready", in_ready, 1);
        check("flush no ghost", out_valid, 0);
        single("after flush", 32'd20, 32'd22, 8'b0011_1100, 32'd42, 4'b0000);
        @(negedge clk);
        check("after flush empty", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog so the run always ends on its own
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
